// File: rtl/frame_load_sequencer.sv
// Run sequencer: loads NUM_RAMS memories from length-prefixed UART frames, runs the processor,
// then streams the result region back over UART Tx. Optional trailing checksum: FRAME_CHECKSUM_EN.
module frame_load_sequencer #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 8,
    parameter int NUM_RAMS = 2,
    parameter int SEL_W    = 1,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              rx_dv,
    input  logic [DATA_W-1:0] rx_byte,
    output logic              mem_wen,
    output logic [SEL_W-1:0]  mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              proc_start_n,
    input  logic              proc_done,
    input  logic [ADDR_W-1:0] proc_tx_last,
    output logic              tx_dv,
    output logic [DATA_W-1:0] tx_byte,
    input  logic              tx_done,
    output logic [1:0]        mode,
    output logic [3:0]        state,
    output logic              load_done,
    output logic              tx_fin,
    output logic              err
);
    localparam int HDR_BYTES = (ADDR_W + DATA_W - 1) / DATA_W;
    localparam int HDR_W     = HDR_BYTES * DATA_W;
    localparam int HCNT_W    = $clog2(HDR_BYTES + 1);
    localparam int RCNT_W    = $clog2(RD_LAT + 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_HDR  = 4'd1,
        S_LOAD = 4'd2,
        S_CHK  = 4'd3,
        S_PROC = 4'd4,
        S_RD   = 4'd5,
        S_WAIT = 4'd6,
        S_DONE = 4'd7
    } state_t;

    state_t             cur_state, state_nxt;
    logic [SEL_W-1:0]   ram_idx, ram_idx_nxt;
    logic [ADDR_W-1:0]  addr, addr_nxt;
    logic [HDR_W-1:0]   len_sr, len_sr_nxt;
    logic [HCNT_W-1:0]  hdr_cnt, hdr_cnt_nxt;
    logic [ADDR_W-1:0]  tx_len, tx_len_nxt;
    logic [RCNT_W-1:0]  rd_cnt, rd_cnt_nxt;
    logic               mem_wen_nxt;
    logic [SEL_W-1:0]   mem_sel_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]  mem_din_nxt;
    logic               tx_dv_nxt;
    logic [DATA_W-1:0]  tx_byte_nxt;
    logic               load_done_nxt, tx_fin_nxt;
    logic               frame_end;
    logic [ADDR_W-1:0]  len;

    // Header bytes arrive LSB first, so each new byte enters at the top and slides down.
    assign len = len_sr[ADDR_W-1:0];

`ifdef FRAME_CHECKSUM_EN
    logic               err_q, err_nxt;
    logic [DATA_W-1:0]  csum, csum_nxt;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign state        = cur_state;
    assign proc_start_n = (cur_state != S_PROC);

    always_comb begin
        case (cur_state)
            S_HDR, S_LOAD, S_CHK: mode = 2'd1;
            S_PROC:               mode = 2'd2;
            S_RD, S_WAIT:         mode = 2'd3;
            default:              mode = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt     = cur_state;
        ram_idx_nxt   = ram_idx;
        addr_nxt      = addr;
        len_sr_nxt    = len_sr;
        hdr_cnt_nxt   = hdr_cnt;
        tx_len_nxt    = tx_len;
        rd_cnt_nxt    = rd_cnt;
        mem_wen_nxt   = 1'b0;
        mem_sel_nxt   = mem_sel;
        mem_addr_nxt  = mem_addr;
        mem_din_nxt   = mem_din;
        tx_dv_nxt     = 1'b0;
        tx_byte_nxt   = tx_byte;
        load_done_nxt = load_done;
        tx_fin_nxt    = tx_fin;
        frame_end     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        err_nxt       = err_q;
        csum_nxt      = csum;
`endif
        case (cur_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt     = S_HDR;
                    ram_idx_nxt   = '0;
                    hdr_cnt_nxt   = '0;
                    len_sr_nxt    = '0;
                    load_done_nxt = 1'b0;
                    tx_fin_nxt    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                    err_nxt       = 1'b0;
`endif
                end
            end
            S_HDR: begin
                if (rx_dv) begin
                    len_sr_nxt = (len_sr >> DATA_W) | (HDR_W'(rx_byte) << (HDR_W - DATA_W));
                    if (hdr_cnt == HCNT_W'(HDR_BYTES - 1)) begin
                        hdr_cnt_nxt = '0;
                        addr_nxt    = '0;
                        state_nxt   = S_LOAD;
`ifdef FRAME_CHECKSUM_EN
                        csum_nxt    = '0;
`endif
                    end else begin
                        hdr_cnt_nxt = hdr_cnt + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (rx_dv) begin
                    mem_wen_nxt  = 1'b1;
                    mem_sel_nxt  = ram_idx;
                    mem_addr_nxt = addr;
                    mem_din_nxt  = rx_byte;
`ifdef FRAME_CHECKSUM_EN
                    csum_nxt     = csum + rx_byte;
`endif
                    if (addr == len) begin
`ifdef FRAME_CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        frame_end = 1'b1;
`endif
                    end else begin
                        addr_nxt = addr + 1'b1;
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CHK: begin
                if (rx_dv) begin
                    if (rx_byte == csum) begin
                        frame_end = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
`endif
            S_PROC: begin
                if (proc_done) begin
                    tx_len_nxt   = proc_tx_last;
                    addr_nxt     = '0;
                    mem_sel_nxt  = '0;
                    mem_addr_nxt = '0;
                    rd_cnt_nxt   = '0;
                    state_nxt    = S_RD;
                end
            end
            S_RD: begin
                // mem_addr was set on entry, so after RD_LAT further cycles mem_dout is settled.
                if (rd_cnt == RCNT_W'(RD_LAT)) begin
                    tx_byte_nxt = mem_dout;
                    tx_dv_nxt   = 1'b1;
                    state_nxt   = S_WAIT;
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (addr == tx_len) begin
                        tx_fin_nxt = 1'b1;
                        state_nxt  = S_DONE;
                    end else begin
                        addr_nxt     = addr + 1'b1;
                        mem_addr_nxt = addr + 1'b1;
                        rd_cnt_nxt   = '0;
                        state_nxt    = S_RD;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (frame_end) begin
            if (ram_idx == SEL_W'(NUM_RAMS - 1)) begin
                load_done_nxt = 1'b1;
                state_nxt     = S_PROC;
            end else begin
                ram_idx_nxt = ram_idx + 1'b1;
                hdr_cnt_nxt = '0;
                state_nxt   = S_HDR;
            end
        end

        // Abort discards everything in flight, including a byte arriving this cycle; err survives.
        if (abort) begin
            state_nxt     = S_IDLE;
            ram_idx_nxt   = '0;
            addr_nxt      = '0;
            len_sr_nxt    = '0;
            hdr_cnt_nxt   = '0;
            tx_len_nxt    = '0;
            rd_cnt_nxt    = '0;
            mem_wen_nxt   = 1'b0;
            mem_sel_nxt   = '0;
            mem_addr_nxt  = '0;
            mem_din_nxt   = '0;
            tx_dv_nxt     = 1'b0;
            tx_byte_nxt   = '0;
            load_done_nxt = 1'b0;
            tx_fin_nxt    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_nxt      = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
            ram_idx   <= '0;
            addr      <= '0;
            len_sr    <= '0;
            hdr_cnt   <= '0;
            tx_len    <= '0;
            rd_cnt    <= '0;
            mem_wen   <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            tx_dv     <= 1'b0;
            tx_byte   <= '0;
            load_done <= 1'b0;
            tx_fin    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            err_q     <= 1'b0;
            csum      <= '0;
`endif
        end else begin
            cur_state <= state_nxt;
            ram_idx   <= ram_idx_nxt;
            addr      <= addr_nxt;
            len_sr    <= len_sr_nxt;
            hdr_cnt   <= hdr_cnt_nxt;
            tx_len    <= tx_len_nxt;
            rd_cnt    <= rd_cnt_nxt;
            mem_wen   <= mem_wen_nxt;
            mem_sel   <= mem_sel_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_din   <= mem_din_nxt;
            tx_dv     <= tx_dv_nxt;
            tx_byte   <= tx_byte_nxt;
            load_done <= load_done_nxt;
            tx_fin    <= tx_fin_nxt;
`ifdef FRAME_CHECKSUM_EN
            err_q     <= err_nxt;
            csum      <= csum_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_frame_load_sequencer.sv
// Testbench for frame_load_sequencer: directed and randomized frames checked against a
// frame-level model of expected RAM writes and transmitted bytes.
module tb_frame_load_sequencer;
    localparam int AW = 18;
    localparam int DW = 8;
    localparam int NR = 2;
    localparam int SW = 1;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          rx_dv = 1'b0;
    logic [DW-1:0] rx_byte = '0;
    logic          mem_wen;
    logic [SW-1:0] mem_sel;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          proc_start_n;
    logic          proc_done = 1'b0;
    logic [AW-1:0] proc_tx_last = '0;
    logic          tx_dv;
    logic [DW-1:0] tx_byte;
    logic          tx_done;
    logic          tx_done_auto = 1'b0;
    logic          tx_done_man = 1'b0;
    logic [1:0]    mode;
    logic [3:0]    state;
    logic          load_done;
    logic          tx_fin;
    logic          err;

    int tests_run = 0;
    int tests_failed = 0;

    assign tx_done = tx_done_auto | tx_done_man;

    frame_load_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_RAMS(NR), .SEL_W(SW), .RD_LAT(RL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rx_dv(rx_dv), .rx_byte(rx_byte),
        .mem_wen(mem_wen), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .proc_start_n(proc_start_n), .proc_done(proc_done), .proc_tx_last(proc_tx_last),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
        .mode(mode), .state(state), .load_done(load_done), .tx_fin(tx_fin), .err(err)
    );

    always #5 clk = ~clk;

    // Memory environment: writes land in the RAM selected, reads appear RL cycles after the address.
    logic [DW-1:0] mem0 [int];
    logic [DW-1:0] mem1 [int];
    logic [DW-1:0] rd_pipe [RL];
    assign mem_dout = rd_pipe[RL-1];

    always @(posedge clk) begin
        logic [DW-1:0] rd;
        if (mem_sel == '0) rd = mem0.exists(int'(mem_addr)) ? mem0[int'(mem_addr)] : 8'h00;
        else               rd = mem1.exists(int'(mem_addr)) ? mem1[int'(mem_addr)] : 8'h00;
        rd_pipe[0] <= rd;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_wen === 1'b1) begin
            if (mem_sel == '0) mem0[int'(mem_addr)] = mem_din;
            else               mem1[int'(mem_addr)] = mem_din;
        end
    end

    // Observation logs and the uart_tx stand-in.
    logic [SW+AW+DW-1:0] wr_q[$];
    logic [SW+AW+DW-1:0] exp_wr[$];
    logic [DW-1:0]       exp_dram [int];
    logic [DW-1:0]       txb_q[$];
    logic [DW-1:0]       done_q[$];
    int                  age_q[$];
    logic [AW-1:0]       prev_addr = '0;
    int                  addr_age = 0;
    int                  tx_cnt = 0;
    logic                auto_tx = 1'b1;

    always @(negedge clk) begin
        if (mem_addr !== prev_addr) begin
            prev_addr = mem_addr;
            addr_age  = 0;
        end else begin
            addr_age++;
        end
        if (mem_wen === 1'b1) wr_q.push_back({mem_sel, mem_addr, mem_din});
        tx_done_auto = 1'b0;
        if (tx_cnt != 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done_auto = 1'b1;
                done_q.push_back(tx_byte);
            end
        end
        if (tx_dv === 1'b1) begin
            txb_q.push_back(tx_byte);
            age_q.push_back(addr_age);
            if (auto_tx) tx_cnt = 3;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [DW-1:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = DW'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // One frame: LE header of the last address, payload and, when enabled, the checksum byte.
    task automatic applyStimulus(input int sel, input logic [DW-1:0] data[$]);
        logic [23:0]   last;
        logic [DW-1:0] sum;
        last = 24'(data.size() - 1);
        sum  = '0;
        sendByte(last[7:0]);
        sendByte(last[15:8]);
        sendByte(last[23:16]);
        for (int i = 0; i < data.size(); i++) begin
            sendByte(data[i]);
            sum = sum + data[i];
            exp_wr.push_back({SW'(sel), AW'(i), data[i]});
            if (sel == 0) exp_dram[i] = data[i];
        end
`ifdef FRAME_CHECKSUM_EN
        sendByte(sum);
`endif
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseProc(input int last);
        proc_tx_last = AW'(last);
        proc_done    = 1'b1;
        @(negedge clk);
        proc_done    = 1'b0;
    endtask

    task automatic waitState(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, state, s);
    endtask

    task automatic checkWrites(input string tag);
        @(negedge clk);
        checkOutput({tag, "_count"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
            checkOutput($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_wr[i]);
        wr_q.delete();
        exp_wr.delete();
    endtask

    task automatic checkTx(input string tag, input int last);
        logic [DW-1:0] e;
        checkOutput({tag, "_txcount"}, txb_q.size(), last + 1);
        checkOutput({tag, "_donecount"}, done_q.size(), last + 1);
        for (int i = 0; i <= last && i < txb_q.size(); i++) begin
            e = exp_dram.exists(i) ? exp_dram[i] : 8'h00;
            checkOutput($sformatf("%s_tx%0d", tag, i), txb_q[i], e);
            checkOutput($sformatf("%s_lat%0d", tag, i), 32'(age_q[i] >= RL), 1);
            if (i < done_q.size()) checkOutput($sformatf("%s_hold%0d", tag, i), done_q[i], e);
        end
        txb_q.delete();
        done_q.delete();
        age_q.delete();
    endtask

    task automatic randomRun(input string tag, input int fixed_last);
        logic [DW-1:0] d0[$];
        logic [DW-1:0] d1[$];
        int n0, n1, last;
        n0 = (fixed_last >= 0) ? $urandom_range(fixed_last + 1, 6) : $urandom_range(1, 6);
        n1 = $urandom_range(1, 4);
        for (int i = 0; i < n0; i++) d0.push_back(DW'($urandom));
        for (int i = 0; i < n1; i++) d1.push_back(DW'($urandom));
        last = (fixed_last >= 0) ? fixed_last : $urandom_range(0, n0 - 1);
        pulseStart();
        checkOutput({tag, "_ld_clr"}, load_done, 0);
        checkOutput({tag, "_fin_clr"}, tx_fin, 0);
        pulseProc(5);
        checkOutput({tag, "_stray_proc"}, state, 1);
        applyStimulus(0, d0);
        applyStimulus(1, d1);
        checkOutput({tag, "_proc"}, state, 4);
        checkOutput({tag, "_ld"}, load_done, 1);
        sendByte(8'h5E);
        tx_done_man = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b0;
        checkOutput({tag, "_stray_txd"}, state, 4);
        checkWrites(tag);
        pulseProc(last);
        waitState(4'd7, 600, {tag, "_done"});
        checkTx(tag, last);
        checkOutput({tag, "_fin"}, tx_fin, 1);
    endtask

    initial begin
        logic [DW-1:0] q[$];

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_wen", mem_wen, 0);
        checkOutput("rst_sel", mem_sel, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_din", mem_din, 0);
        checkOutput("rst_psn", proc_start_n, 1);
        checkOutput("rst_txdv", tx_dv, 0);
        checkOutput("rst_txbyte", tx_byte, 0);
        checkOutput("rst_mode", mode, 0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_ld", load_done, 0);
        checkOutput("rst_fin", tx_fin, 0);
        checkOutput("rst_err", err, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed two-RAM load, then read back Dram[0..2]
        pulseStart();
        checkOutput("t1_hdr_mode", mode, 1);
        q = {8'hAA, 8'hBB, 8'hCC};
        applyStimulus(0, q);
        q = {8'h11};
        applyStimulus(1, q);
        checkOutput("t1_ld", load_done, 1);
        checkOutput("t1_mode", mode, 2);
        checkOutput("t1_state", state, 4);
        checkOutput("t1_psn", proc_start_n, 0);
        checkWrites("t1");
        pulseProc(2);
        checkOutput("t1_tx_mode", mode, 3);
        waitState(4'd7, 400, "t1_done");
        checkTx("t1", 2);
        checkOutput("t1_fin", tx_fin, 1);
        checkOutput("t1_psn_done", proc_start_n, 1);

        // Header 0 loads exactly one byte
        pulseStart();
        checkOutput("t2_ld_clr", load_done, 0);
        checkOutput("t2_fin_clr", tx_fin, 0);
        q = {8'h5A};
        applyStimulus(0, q);
        q = {8'h77};
        applyStimulus(1, q);
        checkOutput("t2_state", state, 4);
        checkWrites("t2");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("t2_abort_state", state, 0);
        checkOutput("t2_abort_ld", load_done, 0);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checkOutput("t2_start_abort", state, 0);

        // Abort coincident with the second payload byte
        pulseStart();
        sendByte(8'h02);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'hAA);
        exp_wr.push_back({SW'(0), AW'(0), 8'hAA});
        exp_dram[0] = 8'hAA;
        rx_byte = 8'hBB;
        rx_dv   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
        abort   = 1'b0;
        checkOutput("t4_wen", mem_wen, 0);
        checkOutput("t4_state", state, 0);
        checkOutput("t4_mode", mode, 0);
        checkOutput("t4_psn", proc_start_n, 1);
        checkWrites("t4");

`ifdef FRAME_CHECKSUM_EN
        // Bad checksum aborts the run and sets err; a good one proceeds
        pulseStart();
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h02);
        sendByte(8'h04);
        exp_wr.push_back({SW'(0), AW'(0), 8'h01});
        exp_wr.push_back({SW'(0), AW'(1), 8'h02});
        checkOutput("t5_err", err, 1);
        checkOutput("t5_state", state, 0);
        pulseStart();
        checkOutput("t5_err_clr", err, 0);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h02);
        sendByte(8'h03);
        exp_wr.push_back({SW'(0), AW'(0), 8'h01});
        exp_wr.push_back({SW'(0), AW'(1), 8'h02});
        exp_dram[0] = 8'h01;
        exp_dram[1] = 8'h02;
        checkOutput("t5_ok_state", state, 1);
        checkOutput("t5_ok_err", err, 0);
        checkWrites("t5");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif

        // Asynchronous reset while waiting on tx_done
        pulseStart();
        q = {8'h31, 8'h32};
        applyStimulus(0, q);
        q = {8'h41};
        applyStimulus(1, q);
        checkWrites("t6");
        auto_tx = 1'b0;
        pulseProc(1);
        waitState(4'd6, 50, "t6_wait");
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_state", state, 0);
        checkOutput("t6_psn", proc_start_n, 1);
        checkOutput("t6_mode", mode, 0);
        checkOutput("t6_txbyte", tx_byte, 0);
        checkOutput("t6_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        tx_done_man = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b0;
        @(negedge clk);
        checkOutput("t6_late_done", state, 0);
        checkOutput("t6_fin", tx_fin, 0);
        txb_q.delete();
        done_q.delete();
        age_q.delete();
        auto_tx = 1'b1;

        // Randomized runs; the first reads back Dram[0..3]
        randomRun("r0", 3);
        for (int k = 1; k < 4; k++) randomRun($sformatf("r%0d", k), -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
